// File: rtl/paint_pkg.sv
// Shared types and bit positions for the paint command scheduler.
package paint_pkg;

  typedef enum logic [1:0] {
    S_Idle = 2'd0,
    S_Req  = 2'd1,
    S_Gap  = 2'd2
  } state_t;

  localparam int CFG_ENABLE = 0;
  localparam int CFG_FLUSH  = 1;
  localparam int CFG_CLEAR  = 2;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_TIMEOUT   = 4;
  localparam int ST_COUNT_LSB = 5;

  // The Status count field is only 3 bits wide, so deep FIFOs report 7.
  function automatic logic [2:0] sat_count(input logic [4:0] cnt);
    return (cnt > 5'd7) ? 3'd7 : cnt[2:0];
  endfunction

endpackage

// File: rtl/paint_fifo.sv
// Command FIFO: power-of-two depth, flush has priority over push,
// and a push into a full FIFO is accepted when a pop happens in the same cycle.
module paint_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     theClock,
  input  logic                     theReset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge theClock or negedge theReset) begin
    if (!theReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge theClock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/paint_scheduler.sv
// Queues colour commands and dispatches them one at a time to the painter,
// with an ack timeout and sticky overflow/timeout flags.
//   state  | meaning
//   S_Idle | waiting for enable and a queued command; pops the head on exit
//   S_Req  | paint_req high, counting cycles until paint_ack or timeout
//   S_Gap  | one dead cycle after each transaction
module paint_scheduler
  import paint_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        theClock,
  input  logic        theReset,
  input  logic        Trigger,
  input  logic [7:0]  Red,
  input  logic [7:0]  Green,
  input  logic [7:0]  Blue,
  input  logic [7:0]  ImgNum,
  input  logic [7:0]  Config,
  output logic        paint_req,
  output logic [23:0] paint_rgb,
  output logic [7:0]  paint_img,
  input  logic        paint_ack,
  output logic [7:0]  Status
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t                 state;
  state_t                 state_nxt;
  logic [WW-1:0]          wait_cnt;
  logic                   overflow_flag;
  logic                   timeout_flag;
  logic                   busy;
  logic                   fifo_pop;
  logic                   timeout_evt;
  logic                   overflow_evt;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [31:0]            fifo_rdata;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [4:0]             count_ext;
  logic                   enable;
  logic                   unused_cfg;

  assign enable     = Config[CFG_ENABLE];
  assign unused_cfg = ^Config[7:3];
  assign count_ext  = 5'(fifo_count);

  paint_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .theClock (theClock),
    .theReset (theReset),
    .push     (Trigger),
    .wdata    ({ImgNum, Red, Green, Blue}),
    .pop      (fifo_pop),
    .rdata    (fifo_rdata),
    .flush    (Config[CFG_FLUSH]),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge theClock or negedge theReset) begin
    if (!theReset) state <= S_Idle;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_Idle: if (enable && !fifo_empty) state_nxt = S_Req;
      S_Req:  if (paint_ack || (wait_cnt == WW'(TIMEOUT))) state_nxt = S_Gap;
      S_Gap:  state_nxt = S_Idle;
      default: state_nxt = S_Idle;
    endcase
  end

  always_comb begin
    paint_req    = (state == S_Req);
    busy         = (state == S_Req) || (state == S_Gap);
    fifo_pop     = (state == S_Idle) && enable && !fifo_empty;
    // ack in the expiry cycle counts as success
    timeout_evt  = (state == S_Req) && !paint_ack && (wait_cnt == WW'(TIMEOUT));
    overflow_evt = Trigger && fifo_full && !fifo_pop;
  end

  always_ff @(posedge theClock or negedge theReset) begin
    if (!theReset) begin
      wait_cnt  <= '0;
      paint_rgb <= '0;
      paint_img <= '0;
    end else begin
      if (state == S_Req && state_nxt == S_Req) wait_cnt <= wait_cnt + 1'b1;
      else                                       wait_cnt <= '0;
      if (fifo_pop) begin
        paint_rgb <= fifo_rdata[23:0];
        paint_img <= fifo_rdata[31:24];
      end
    end
  end

  // Sticky flags: a set event outranks a clear in the same cycle.
  always_ff @(posedge theClock or negedge theReset) begin
    if (!theReset) begin
      overflow_flag <= 1'b0;
      timeout_flag  <= 1'b0;
    end else begin
      if (overflow_evt)            overflow_flag <= 1'b1;
      else if (Config[CFG_CLEAR])  overflow_flag <= 1'b0;
      if (timeout_evt)             timeout_flag  <= 1'b1;
      else if (Config[CFG_CLEAR])  timeout_flag  <= 1'b0;
    end
  end

  always_comb begin
    Status                       = '0;
    Status[ST_BUSY]              = busy;
    Status[ST_FULL]              = fifo_full;
    Status[ST_EMPTY]             = fifo_empty;
    Status[ST_OVERFLOW]          = overflow_flag;
    Status[ST_TIMEOUT]           = timeout_flag;
    Status[ST_COUNT_LSB +: 3]    = sat_count(count_ext);
  end

endmodule

// File: tb/tb_paint_scheduler.sv
// Bench for paint_scheduler: vector table for single commands, scoreboard
// queue for dispatch order, hand sequences for overflow/timeout/flush/reset.
module tb_paint_scheduler;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;

  logic        theClock = 1'b0;
  logic        theReset;
  logic        Trigger;
  logic [7:0]  Red, Green, Blue, ImgNum, Config;
  logic        paint_req;
  logic [23:0] paint_rgb;
  logic [7:0]  paint_img;
  logic        paint_ack;
  logic [7:0]  Status;

  typedef struct packed {
    logic [7:0]  img;
    logic [23:0] rgb;
  } cmd_t;

  typedef struct {
    logic [7:0]  r, g, b, img;
    logic [23:0] exp_rgb;
    logic [7:0]  exp_img;
  } vec_t;

  cmd_t exp_q[$];
  cmd_t held;
  logic prev_req = 1'b0;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[3];

  always #5 theClock = ~theClock;

  paint_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .theClock  (theClock),
    .theReset  (theReset),
    .Trigger   (Trigger),
    .Red       (Red),
    .Green     (Green),
    .Blue      (Blue),
    .ImgNum    (ImgNum),
    .Config    (Config),
    .paint_req (paint_req),
    .paint_rgb (paint_rgb),
    .paint_img (paint_img),
    .paint_ack (paint_ack),
    .Status    (Status)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle, then act as the request monitor.
  task automatic tick();
    cmd_t e;
    @(posedge theClock);
    #1;
    if (paint_req && !prev_req) begin
      held = {paint_img, paint_rgb};
      if (exp_q.size() == 0) begin
        chk("unexpected_req", {paint_img, paint_rgb}, 32'hxxxxxxxx);
      end else begin
        e = exp_q.pop_front();
        chk("req_payload", {paint_img, paint_rgb}, e);
      end
    end else if (paint_req && prev_req) begin
      chk("req_stable", {paint_img, paint_rgb}, held);
    end
    prev_req = paint_req;
  endtask

  task automatic trig(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [7:0] img, input bit accept);
    Trigger = 1'b1; Red = r; Green = g; Blue = b; ImgNum = img;
    if (accept) exp_q.push_back({img, r, g, b});
    tick();
    Trigger = 1'b0;
  endtask

  // Ack each request as soon as it appears; between requests expect Gap+Idle.
  task automatic serve(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!paint_req && w < 100) begin
        tick();
        w++;
      end
      chk("serve_req_seen", {31'd0, paint_req}, 32'd1);
      if (i > 0) chk("serve_gap", w, 32'd2);
      paint_ack = 1'b1;
      tick();
      paint_ack = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h05, 24'h112233, 8'h05};
    vecs[1] = '{8'hff, 8'h00, 8'h80, 8'ha5, 24'hff0080, 8'ha5};
    vecs[2] = '{8'h01, 8'h02, 8'h03, 8'hff, 24'h010203, 8'hff};

    theReset = 1'b0; Trigger = 1'b0; paint_ack = 1'b0; Config = 8'h00;
    Red = 8'h0; Green = 8'h0; Blue = 8'h0; ImgNum = 8'h0;
    #12;
    chk("reset_status", Status, 32'h04);
    chk("reset_req", paint_req, 32'd0);
    chk("reset_rgb", paint_rgb, 32'd0);
    chk("reset_img", paint_img, 32'd0);
    @(posedge theClock); #1;
    theReset = 1'b1;
    tick();

    // single commands: latency N+2, payload, busy drops two cycles after ack
    Config = 8'h01;
    tick();
    foreach (vecs[k]) begin
      trig(vecs[k].r, vecs[k].g, vecs[k].b, vecs[k].img, 1'b1);
      chk("lat_n1_req", paint_req, 32'd0);
      tick();
      chk("lat_n2_req", paint_req, 32'd1);
      chk("vec_rgb", paint_rgb, vecs[k].exp_rgb);
      chk("vec_img", paint_img, vecs[k].exp_img);
      paint_ack = 1'b1;
      tick();
      paint_ack = 1'b0;
      chk("gap_busy", Status[0], 32'd1);
      chk("gap_req", paint_req, 32'd0);
      tick();
      chk("idle_status", Status, 32'h04);
    end

    // stray ack while idle
    paint_ack = 1'b1;
    tick();
    paint_ack = 1'b0;
    tick();
    chk("stray_ack_status", Status, 32'h04);
    chk("stray_ack_req", paint_req, 32'd0);

    // overflow: five pushes into a depth-4 FIFO while dispatch disabled
    Config = 8'h00;
    for (int i = 0; i < 5; i++)
      trig(8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i), 8'h40 + 8'(i), i < 4);
    chk("ovf_status", Status, 32'h8A);
    Config = 8'h01;
    serve(4);
    repeat (5) tick();
    chk("ovf_drained_status", Status, 32'h0C);
    Config = 8'h05;
    tick();
    Config = 8'h01;
    chk("ovf_cleared", Status, 32'h04);

    // timeout, with a clear in the expiry cycle losing to the set
    trig(8'haa, 8'hbb, 8'hcc, 8'h07, 1'b1);
    tick();
    chk("to_req_start", paint_req, 32'd1);
    repeat (TIMEOUT) tick();
    chk("to_req_at_limit", paint_req, 32'd1);
    Config = 8'h05;
    tick();
    Config = 8'h01;
    chk("to_req_dropped", paint_req, 32'd0);
    chk("to_status_set", Status, 32'h15);
    Config = 8'h05;
    tick();
    Config = 8'h01;
    chk("to_cleared", Status, 32'h04);

    // ack in the expiry cycle wins
    trig(8'h12, 8'h34, 8'h56, 8'h08, 1'b1);
    tick();
    repeat (TIMEOUT) tick();
    chk("coinc_req", paint_req, 32'd1);
    paint_ack = 1'b1;
    tick();
    paint_ack = 1'b0;
    chk("coinc_status", Status, 32'h05);
    tick();
    chk("coinc_idle", Status, 32'h04);

    // full FIFO: pop and push in the same cycle
    Config = 8'h00;
    for (int i = 0; i < 4; i++)
      trig(8'h50 + 8'(i), 8'h60 + 8'(i), 8'h70 + 8'(i), 8'h80 + 8'(i), 1'b1);
    chk("full_status", Status, 32'h82);
    Config = 8'h01;
    trig(8'h99, 8'h98, 8'h97, 8'h96, 1'b1);
    chk("pushpop_status", Status, 32'h83);
    chk("pushpop_req", paint_req, 32'd1);
    serve(5);
    tick();
    tick();
    chk("pushpop_done", Status, 32'h04);

    // flush during S_Req with three queued; push in the flush cycle is lost
    Config = 8'h00;
    for (int i = 0; i < 4; i++)
      trig(8'ha0 + 8'(i), 8'hb0 + 8'(i), 8'hc0 + 8'(i), 8'hd0 + 8'(i), 1'b1);
    Config = 8'h01;
    tick();
    chk("flush_pre_req", paint_req, 32'd1);
    Config = 8'h03;
    Trigger = 1'b1; Red = 8'hee; Green = 8'hee; Blue = 8'hee; ImgNum = 8'hee;
    tick();
    Trigger = 1'b0;
    Config = 8'h01;
    exp_q.delete();
    chk("flush_req_kept", paint_req, 32'd1);
    chk("flush_status", Status, 32'h05);
    paint_ack = 1'b1;
    tick();
    paint_ack = 1'b0;
    repeat (10) tick();
    chk("flush_no_req", paint_req, 32'd0);
    chk("flush_final", Status, 32'h04);

    // asynchronous reset in the middle of S_Req
    trig(8'h0a, 8'h0b, 8'h0c, 8'h0d, 1'b1);
    tick();
    chk("rst_pre_req", paint_req, 32'd1);
    theReset = 1'b0;
    #1;
    chk("rst_async_req", paint_req, 32'd0);
    chk("rst_async_status", Status, 32'h04);
    chk("rst_async_rgb", paint_rgb, 32'd0);
    tick();
    theReset = 1'b1;
    repeat (3) tick();
    chk("rst_after_req", paint_req, 32'd0);
    chk("rst_after_status", Status, 32'h04);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/paint_scheduler.md
PAINT_SCHEDULER -- requirements
Module: paint_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the command FIFO depth (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 1023, SHALL set the maximum cycles paint_req waits for paint_ack.
REQ-003 theClock  in  1  single system clock; all state SHALL change on its rising edge.
REQ-004 theReset  in  1  asynchronous, active-low reset.
REQ-005 Trigger  in  1  one-cycle pulse; the command on Red/Green/Blue/ImgNum is valid this cycle.
REQ-006 Red, Green, Blue, ImgNum  in  8 each  command payload, sampled only when Trigger=1.
REQ-007 Config  in  8  bit0 enable dispatch, bit1 flush FIFO (level), bit2 clear sticky flags (level).
REQ-008 paint_req  out  1  request to the painter datapath.
REQ-009 paint_rgb  out  24  {Red,Green,Blue} of the in-flight command, stable while paint_req=1.
REQ-010 paint_img  out  8  ImgNum of the in-flight command, stable while paint_req=1.
REQ-011 paint_ack  in  1  one-cycle completion pulse from the painter.
REQ-012 Status  out  8  bit0 busy, bit1 full, bit2 empty, bit3 overflow, bit4 timeout, bits7:5 count (saturating at 7).

Function
REQ-013 On Trigger=1 with the FIFO not full, the payload SHALL be pushed; count SHALL rise at the next edge.
REQ-014 On Trigger=1 with the FIFO full and no pop that cycle, the command SHALL be dropped and overflow SHALL be set.
REQ-015 A push and a pop in the same cycle SHALL both take effect, leaving count unchanged, including when full.
REQ-016 Commands SHALL be pushed regardless of Config bit0.
REQ-017 The FSM SHALL have the states S_Idle, S_Req and S_Gap.
REQ-018 S_Idle: if enable=1 and the FIFO is not empty, the FSM SHALL pop the head into paint_rgb/paint_img and go to S_Req; otherwise it SHALL stay in S_Idle.
REQ-019 S_Req: paint_req SHALL be 1 and a wait counter SHALL increment each cycle from 0.
REQ-020 In S_Req, paint_ack=1 SHALL take the FSM to S_Gap.
REQ-021 In S_Req, a wait counter equal to TIMEOUT with paint_ack=0 SHALL set timeout, discard the command and go to S_Gap.
REQ-022 If paint_ack and timeout expiry coincide, paint_ack SHALL win and timeout SHALL not be set.
REQ-023 S_Gap SHALL last exactly one cycle with paint_req=0, then return to S_Idle.
REQ-024 paint_ack outside S_Req SHALL be ignored.
REQ-025 Latency: with the FIFO empty and the FSM in S_Idle with enable=1, Trigger in cycle N SHALL give paint_req=1 in cycle N+2.
REQ-026 Back-to-back commands SHALL have a minimum of 1 idle cycle (S_Gap) plus 1 cycle (S_Idle) between requests.
REQ-027 Flush=1 SHALL empty the FIFO at the next edge and override any push that cycle.
REQ-028 Flush SHALL not abort an in-flight S_Req transaction.
REQ-029 Clearing enable mid-transaction SHALL let the current transaction complete; no new pop SHALL occur.
REQ-030 Clear=1 SHALL zero overflow and timeout; a set event in the same cycle SHALL take priority.
REQ-031 busy SHALL be 1 in S_Req and S_Gap.
REQ-032 empty and full SHALL reflect count==0 and count==DEPTH, registered.

Reset
REQ-033 theReset=0 SHALL immediately force: FSM to S_Idle, FIFO empty, wait counter 0, paint_req 0, paint_rgb 0, paint_img 0, flags 0.
REQ-034 After reset, Status SHALL read 8'h04.
REQ-035 Reset during S_Req SHALL drop paint_req asynchronously; the in-flight command is lost.

Structure
REQ-036 The package paint_pkg SHALL hold the state enum, Config bit indices and Status bit indices.
REQ-037 Storage SHALL be a sub-module paint_fifo (32-bit wide, DEPTH deep) with push, pop, flush, full, empty and count ports.

Verification
REQ-038 Reset then enable=1, one Trigger with RGB 11/22/33 and ImgNum 05 -> paint_req at N+2, paint_rgb=24'h112233, paint_img=8'h05; ack -> busy drops 2 cycles later.
REQ-039 enable=0, 5 Triggers with DEPTH=4 -> count=4, full=1, overflow=1; enable=1 -> exactly 4 requests in push order.
REQ-040 paint_ack held 0 -> paint_req drops after TIMEOUT+1 cycles, timeout=1; Config bit2 pulse -> Status bit4=0.
REQ-041 FIFO full while S_Idle pops and a Trigger arrives in the same cycle -> push accepted, count stays 4, overflow=0.
REQ-042 Flush during S_Req with 3 queued -> in-flight completes on ack, no further requests, empty=1.
REQ-043 theReset=0 mid-S_Req -> paint_req=0 without a clock edge; Status=8'h04.
